// File: rtl/cdb_broadcaster_if.sv
// Common-data-bus handshake bundle: functional-unit result inputs, consumer
// controls and the registered broadcast outputs.
interface cdb_broadcaster_if #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]        fu_valid;
  logic [N_SRC-1:0]        fu_ready;
  logic [N_SRC*TAG_W-1:0]  fu_tag;
  logic [N_SRC*DATA_W-1:0] fu_data;
  logic                    cdb_stall;
  logic                    flush;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;

  // master: the broadcaster itself; slave: the sources/consumers around it
  modport master (
    input  fu_valid, fu_tag, fu_data, cdb_stall, flush,
    output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    output fu_valid, fu_tag, fu_data, cdb_stall, flush,
    input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// CDB broadcaster: round-robin grant of one completed FU result per cycle,
// driven onto a registered tag/value broadcast.
module cdb_broadcaster #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  cdb_broadcaster_if.master bus
);
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  gnt_idx;
  logic [SRC_W-1:0]  probe;
  logic              gnt_found;
  logic              gnt_ok;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  // Search rr_ptr, rr_ptr+1, ... ; the index wraps naturally since N_SRC is 2^SRC_W
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    probe     = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      probe = rr_ptr + SRC_W'(k);
      if (!gnt_found && bus.fu_valid[probe]) begin
        gnt_found = 1'b1;
        gnt_idx   = probe;
      end
    end
  end

  assign gnt_ok = gnt_found && !bus.flush && !bus.cdb_stall && rst_n;

  always_comb begin
    bus.fu_ready = '0;
    sel_tag      = '0;
    sel_data     = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        bus.fu_ready[i] = gnt_ok;
        sel_tag         = bus.fu_tag[i*TAG_W +: TAG_W];
        sel_data        = bus.fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
      bus.cdb_src   <= '0;
    end else if (gnt_ok) begin
      rr_ptr        <= gnt_idx + SRC_W'(1);
      bus.cdb_valid <= 1'b1;
      bus.cdb_tag   <= sel_tag;
      bus.cdb_data  <= sel_data;
      bus.cdb_src   <= gnt_idx;
    end else begin
      bus.cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: hand-computed vector table, directed corner
// sequences and randomized traffic against a queue-free arithmetic model.
module tb_cdb_broadcaster;
  localparam int N = 4;

  logic clk;
  logic rst_n;

  cdb_broadcaster_if #(.N_SRC(4), .TAG_W(6), .DATA_W(32)) bus ();

  cdb_broadcaster #(.N_SRC(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [5:0]  src_tag  [N];
  logic [31:0] src_data [N];

  // reference model state
  int          m_ptr;
  logic        m_valid;
  logic [5:0]  m_tag;
  logic [31:0] m_data;
  logic [1:0]  m_src;

  typedef struct {
    logic [3:0] v;
    logic       st;
    logic       fl;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [5:0] exp_tag;
    logic [1:0] exp_src;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = '0;
  endtask

  // Entered at posedge+1; returns at the next posedge+1 with outputs checked.
  task automatic step(input logic [3:0] v, input logic st, input logic fl,
                      output logic [3:0] act_ready);
    int j;
    logic [3:0] exp_ready;
    bus.fu_valid  = v;
    bus.cdb_stall = st;
    bus.flush     = fl;
    for (int i = 0; i < N; i++) begin
      bus.fu_tag[i*6 +: 6]    = src_tag[i];
      bus.fu_data[i*32 +: 32] = src_data[i];
    end
    #3;
    j = pick(v, m_ptr);
    exp_ready = (j >= 0 && !st && !fl) ? 4'(1 << j) : 4'b0000;
    act_ready = bus.fu_ready;
    check("fu_ready", 64'(bus.fu_ready), 64'(exp_ready));
    check("cdb_valid_before_edge", 64'(bus.cdb_valid), 64'(m_valid));
    @(posedge clk);
    #1;
    if (exp_ready != 4'b0000) begin
      m_valid = 1'b1; m_tag = src_tag[j]; m_data = src_data[j];
      m_src = 2'(j); m_ptr = (j + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
    check("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    check("cdb_tag",   64'(bus.cdb_tag),   64'(m_tag));
    check("cdb_data",  64'(bus.cdb_data),  64'(m_data));
    check("cdb_src",   64'(bus.cdb_src),   64'(m_src));
  endtask

  logic [3:0] rdy;
  logic [3:0] v;
  logic       st, fl;
  logic [3:0] held;
  int         wait_cnt [N];

  initial begin
    rst_n = 1'b1;
    bus.fu_valid = '1; bus.cdb_stall = 1'b0; bus.flush = 1'b0;
    bus.fu_tag = '0; bus.fu_data = '0;
    for (int i = 0; i < N; i++) begin
      src_tag[i] = 6'(10 + i); src_data[i] = 32'hA000_0000 + 32'(i);
    end
    tbl[0]  = '{4'b1111, 0, 0, 4'b0001, 1, 6'd10, 2'd0};
    tbl[1]  = '{4'b1111, 0, 0, 4'b0010, 1, 6'd11, 2'd1};
    tbl[2]  = '{4'b0001, 0, 0, 4'b0001, 1, 6'd10, 2'd0};
    tbl[3]  = '{4'b1111, 1, 0, 4'b0000, 0, 6'd10, 2'd0};
    tbl[4]  = '{4'b1111, 0, 1, 4'b0000, 0, 6'd10, 2'd0};
    tbl[5]  = '{4'b1000, 0, 0, 4'b1000, 1, 6'd13, 2'd3};
    tbl[6]  = '{4'b0000, 0, 0, 4'b0000, 0, 6'd13, 2'd3};
    tbl[7]  = '{4'b0110, 0, 0, 4'b0010, 1, 6'd11, 2'd1};
    tbl[8]  = '{4'b0110, 0, 0, 4'b0100, 1, 6'd12, 2'd2};
    tbl[9]  = '{4'b1001, 0, 0, 4'b1000, 1, 6'd13, 2'd3};
    tbl[10] = '{4'b1001, 0, 0, 4'b0001, 1, 6'd10, 2'd0};

    // Asynchronous reset with all sources valid, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("reset_fu_ready", 64'(bus.fu_ready), 64'(0));
    check("reset_cdb_valid", 64'(bus.cdb_valid), 64'(0));
    check("reset_cdb_tag", 64'(bus.cdb_tag), 64'(0));
    check("reset_cdb_data", 64'(bus.cdb_data), 64'(0));
    check("reset_cdb_src", 64'(bus.cdb_src), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();

    // Vector table from reset; rows 9-10 exercise the 3 -> 0 wrap
    for (int r = 0; r < 11; r++) begin
      step(tbl[r].v, tbl[r].st, tbl[r].fl, rdy);
      check($sformatf("tbl%0d_ready", r), 64'(rdy), 64'(tbl[r].exp_ready));
      check($sformatf("tbl%0d_valid", r), 64'(bus.cdb_valid), 64'(tbl[r].exp_valid));
      check($sformatf("tbl%0d_tag", r), 64'(bus.cdb_tag), 64'(tbl[r].exp_tag));
      check($sformatf("tbl%0d_src", r), 64'(bus.cdb_src), 64'(tbl[r].exp_src));
    end
    check("wrap_rr_ptr", 64'(dut.rr_ptr), 64'(1));

    // Single source held three cycles: back-to-back broadcasts
    src_tag[2] = 6'd17; src_data[2] = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      step(4'b0100, 0, 0, rdy);
      check("single_ready", 64'(rdy), 64'(4'b0100));
      check("single_tag", 64'(bus.cdb_tag), 64'(17));
      check("single_data", 64'(bus.cdb_data), 64'(32'hDEADBEEF));
      check("single_src", 64'(bus.cdb_src), 64'(2));
      check("single_valid", 64'(bus.cdb_valid), 64'(1));
    end

    // Stall two cycles with all valid: pointer must not move
    step(4'b1111, 1, 0, rdy);
    step(4'b1111, 1, 0, rdy);
    check("stall_valid", 64'(bus.cdb_valid), 64'(0));
    check("stall_rr_ptr", 64'(dut.rr_ptr), 64'(3));
    // A live broadcast still shows through a flush cycle; step checks it pre-edge
    step(4'b1111, 0, 0, rdy);
    check("preflush_valid", 64'(bus.cdb_valid), 64'(1));
    step(4'b1111, 0, 1, rdy);
    check("flush_ready", 64'(rdy), 64'(0));
    check("flush_rr_ptr", 64'(dut.rr_ptr), 64'(0));

    // Round-robin order from reset with tags 1..4, including tag 0 afterwards
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) src_tag[i] = 6'(i + 1);
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 0, 0, rdy);
      check("rr_order_tag", 64'(bus.cdb_tag), 64'((c % 4) + 1));
      check("rr_order_valid", 64'(bus.cdb_valid), 64'(1));
    end
    src_tag[0] = 6'd0;
    step(4'b0001, 0, 0, rdy);
    check("tag0_valid", 64'(bus.cdb_valid), 64'(1));
    check("tag0_tag", 64'(bus.cdb_tag), 64'(0));

    // Async reset between edges while broadcasting
    step(4'b1111, 0, 0, rdy);
    check("midrst_pre_valid", 64'(bus.cdb_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.cdb_valid), 64'(0));
    check("midrst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
    check("midrst_ready", 64'(bus.fu_ready), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    step(4'b1111, 0, 0, rdy);
    check("postrst_src", 64'(bus.cdb_src), 64'(0));

    // Randomized traffic; sources hold until accepted, fairness tracked per source
    held = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (held[i]) v[i] = 1'b1;
        else begin
          v[i] = 1'($urandom_range(0, 1));
          src_tag[i]  = 6'($urandom_range(0, 63));
          src_data[i] = $urandom;
        end
      end
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 15) == 0);
      step(v, st, fl, rdy);
      for (int i = 0; i < N; i++) begin
        if (v[i] && rdy[i]) begin
          check($sformatf("fair_src%0d", i), 64'(wait_cnt[i] < N), 64'(1));
          wait_cnt[i] = 0;
        end else if (v[i] && !st && !fl) begin
          wait_cnt[i]++;
        end
        held[i] = v[i] && !rdy[i];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
